// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 compression core: chains pre-padded 512-bit blocks, RND_PER_CYC rounds per clock.
// Optional SHA-224 IV/truncation selected by defining SHA224_MODE_EN (adds the mode_224 port).

module sha256_round (
  input  logic [0:7][31:0] st_in,
  input  logic [31:0]      k,
  input  logic [31:0]      w,
  output logic [0:7][31:0] st_out
);
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] s1, ch, t1, s0, maj, t2;

  always_comb begin
    s1  = rotr(st_in[4], 6) ^ rotr(st_in[4], 11) ^ rotr(st_in[4], 25);
    ch  = (st_in[4] & st_in[5]) ^ (~st_in[4] & st_in[6]);
    t1  = st_in[7] + s1 + ch + k + w;
    s0  = rotr(st_in[0], 2) ^ rotr(st_in[0], 13) ^ rotr(st_in[0], 22);
    maj = (st_in[0] & st_in[1]) ^ (st_in[0] & st_in[2]) ^ (st_in[1] & st_in[2]);
    t2  = s0 + maj;
    st_out    = st_in;
    st_out[0] = t1 + t2;
    st_out[1] = st_in[0];
    st_out[2] = st_in[1];
    st_out[3] = st_in[2];
    st_out[4] = st_in[3] + t1;
    st_out[5] = st_in[4];
    st_out[6] = st_in[5];
    st_out[7] = st_in[6];
  end
endmodule

module sha256_stream_core #(
  parameter int RND_PER_CYC = 1,
  parameter int DEPTH_W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA224_MODE_EN
  input  logic         mode_224,
`endif
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         busy
);

  if (RND_PER_CYC != 1 && RND_PER_CYC != 2 && RND_PER_CYC != 4) begin : g_bad_rnd
    $fatal(1, "sha256_stream_core: RND_PER_CYC must be 1, 2 or 4");
  end
  if ((1 << DEPTH_W) <= 64) begin : g_bad_depth
    $fatal(1, "sha256_stream_core: DEPTH_W too small for 64 rounds");
  end

  localparam logic [0:7][31:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA224_MODE_EN
  localparam logic [0:7][31:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [DEPTH_W-1:0] CNT_LAST = DEPTH_W'(64 - RND_PER_CYC);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, FIN, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               rst_sync;
  logic                     srst_n;
  logic [0:7][31:0]         chain, vars, chain_sum, dig_nxt, iv_sel;
  logic [0:15][31:0]        w, w_nxt;
  logic [0:15+RND_PER_CYC][31:0] wx;
  logic [DEPTH_W-1:0]       cnt;
  logic                     last_q;
  logic [0:7][31:0]         st [RND_PER_CYC+1];
`ifdef SHA224_MODE_EN
  logic                     mode_q;
`endif

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign srst_n = rst_sync[1];

  assign blk_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

`ifdef SHA224_MODE_EN
  assign iv_sel = mode_224 ? IV224 : IV256;
`else
  assign iv_sel = IV256;
`endif

  // Window extension: words 16.. are the next schedule words; words 0..R-1 feed this cycle's rounds.
  always_comb begin
    wx = '0;
    for (int i = 0; i < 16; i++) wx[i] = w[i];
    for (int j = 0; j < RND_PER_CYC; j++)
      wx[16+j] = ssig1(wx[14+j]) + wx[9+j] + ssig0(wx[1+j]) + wx[j];
    w_nxt = '0;
    for (int i = 0; i < 16; i++) w_nxt[i] = wx[i+RND_PER_CYC];
  end

  assign st[0] = vars;
  for (genvar j = 0; j < RND_PER_CYC; j++) begin : g_rnd
    logic [5:0] kidx;
    assign kidx = cnt[5:0] + 6'(j);
    sha256_round u_rnd (
      .st_in  (st[j]),
      .k      (K[kidx]),
      .w      (wx[j]),
      .st_out (st[j+1])
    );
  end

  always_comb begin
    chain_sum = '0;
    for (int i = 0; i < 8; i++) chain_sum[i] = chain[i] + vars[i];
    dig_nxt = chain_sum;
`ifdef SHA224_MODE_EN
    if (mode_q) dig_nxt[7] = 32'h0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (blk_valid) state_d = RUN;
      RUN:     if (cnt == CNT_LAST) state_d = FIN;
      FIN:     state_d = last_q ? HOLD : IDLE;
      HOLD:    if (dig_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A first block reloads the chain with the IV so FIN always adds to the chain.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      chain     <= IV256;
      vars      <= '0;
      w         <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      dig_valid <= 1'b0;
      dig_data  <= '0;
`ifdef SHA224_MODE_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (blk_valid) begin
          w      <= blk_data;
          vars   <= blk_first ? iv_sel : chain;
          if (blk_first) chain <= iv_sel;
          last_q <= blk_last;
          cnt    <= '0;
`ifdef SHA224_MODE_EN
          if (blk_first) mode_q <= mode_224;
`endif
        end
        RUN: begin
          vars <= st[RND_PER_CYC];
          w    <= w_nxt;
          cnt  <= cnt + DEPTH_W'(RND_PER_CYC);
        end
        FIN: begin
          chain <= chain_sum;
          if (last_q) begin
            dig_data  <= dig_nxt;
            dig_valid <= 1'b1;
          end
        end
        HOLD: if (dig_ready) dig_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
